// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - KNN class vote over K sorted neighbours, sequential tally scan, valid/ready result.
// Optional rank weighting (vote = K-r) when KNN_VOTE_WEIGHTED_EN is defined.
module knn_vote #(
    parameter int DATA_W = 32,
    parameter int K      = 4,
    parameter int L      = 8,
    parameter int NCLASS = 16,
`ifdef KNN_VOTE_WEIGHTED_EN
    parameter int VW     = $clog2(K*(K+1)/2+1)
`else
    parameter int VW     = $clog2(K+1)
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                nb_valid,
    input  logic [DATA_W+L-1:0] nb_data,
    output logic                nb_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [L-1:0]        out_label,
    output logic [VW-1:0]       out_votes,
    output logic                out_none
);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        r_state;
    logic [VW-1:0] r_cnt   [NCLASS];
    logic [RW-1:0] r_first [NCLASS];
    logic [RW-1:0] r_idx;
    logic [CW-1:0] r_c;
    logic [VW-1:0] r_best_cnt;
    logic [RW-1:0] r_best_first;
    logic [CW-1:0] r_best_lbl;
    logic          r_nb_ready;
    logic          r_out_valid;
    logic          r_out_none;
    logic [L-1:0]  r_out_label;
    logic [VW-1:0] r_out_votes;

    logic [L-1:0]  w_lbl;
    logic [CW-1:0] w_lbl_idx;
    logic          w_lbl_ok;
    logic          w_acc;
    logic          w_take;
    logic          w_clr_cnt;
    logic [VW-1:0] w_wt;
    logic          w_unused_dist;

    assign w_lbl         = nb_data[L-1:0];
    assign w_lbl_idx     = w_lbl[CW-1:0];
    assign w_lbl_ok      = 32'(w_lbl) < 32'(NCLASS);
    assign w_unused_dist = ^nb_data[DATA_W+L-1:L];
    assign w_acc         = nb_valid & r_nb_ready;
    assign w_clr_cnt     = clr | ((r_state == DONE) & r_out_valid & out_ready);
`ifdef KNN_VOTE_WEIGHTED_EN
    assign w_wt = VW'(K) - VW'(r_idx);
`else
    assign w_wt = VW'(1);
`endif

    // Equal tallies are won by the class whose first hit had the lower rank (nearer neighbour).
    assign w_take = (r_cnt[r_c] > r_best_cnt) ||
                    ((r_cnt[r_c] == r_best_cnt) && (r_cnt[r_c] != '0) &&
                     (r_first[r_c] < r_best_first));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCLASS; i++) begin
                r_cnt[i]   <= '0;
                r_first[i] <= '0;
            end
        end else if (w_clr_cnt) begin
            for (int i = 0; i < NCLASS; i++) begin
                r_cnt[i]   <= '0;
                r_first[i] <= '0;
            end
        end else if (w_acc && w_lbl_ok) begin
            r_cnt[w_lbl_idx] <= r_cnt[w_lbl_idx] + w_wt;
            if (r_cnt[w_lbl_idx] == '0)
                r_first[w_lbl_idx] <= r_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_c          <= '0;
            r_best_cnt   <= '0;
            r_best_first <= '0;
            r_best_lbl   <= '0;
            r_nb_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_none   <= 1'b0;
            r_out_label  <= '0;
            r_out_votes  <= '0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_nb_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_none  <= 1'b0;
            r_out_label <= '0;
            r_out_votes <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (r_idx == RW'(K-1)) begin
                            r_state      <= SCAN;
                            r_nb_ready   <= 1'b0;
                            r_c          <= '0;
                            r_best_cnt   <= '0;
                            r_best_first <= '0;
                            r_best_lbl   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (w_take) begin
                        r_best_cnt   <= r_cnt[r_c];
                        r_best_first <= r_first[r_c];
                        r_best_lbl   <= r_c;
                    end
                    if (r_c == CW'(NCLASS-1))
                        r_state <= DONE;
                    else
                        r_c <= r_c + 1'b1;
                end
                DONE: begin
                    // First DONE cycle registers the result; best_lbl stays 0 when nothing voted.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_none  <= (r_best_cnt == '0);
                        r_out_label <= L'(r_best_lbl);
                        r_out_votes <= r_best_cnt;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_nb_ready  <= 1'b1;
                        r_idx       <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign nb_ready  = r_nb_ready;
    assign out_valid = r_out_valid;
    assign out_label = r_out_label;
    assign out_votes = r_out_votes;
    assign out_none  = r_out_none;
endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - scoreboard bench for knn_vote (honours KNN_VOTE_WEIGHTED_EN when defined).
module tb_knn_vote;
    localparam int DATA_W = 32;
    localparam int K      = 4;
    localparam int L      = 8;
    localparam int NCLASS = 16;
`ifdef KNN_VOTE_WEIGHTED_EN
    localparam int VW = $clog2(K*(K+1)/2+1);
`else
    localparam int VW = $clog2(K+1);
`endif

    typedef int frame_t [K];
    typedef struct {
        int label;
        int votes;
        int none;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clr = 1'b0;
    logic                nb_valid = 1'b0;
    logic [DATA_W+L-1:0] nb_data = '0;
    logic                nb_ready;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [L-1:0]        out_label;
    logic [VW-1:0]       out_votes;
    logic                out_none;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t f;

    knn_vote #(.DATA_W(DATA_W), .K(K), .L(L), .NCLASS(NCLASS)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .nb_valid(nb_valid), .nb_data(nb_data), .nb_ready(nb_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_votes(out_votes), .out_none(out_none)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input frame_t fr);
        int   cnt [NCLASS];
        int   first [NCLASS];
        exp_t e;
        for (int c = 0; c < NCLASS; c++) begin
            cnt[c]   = 0;
            first[c] = 0;
        end
        for (int r = 0; r < K; r++) begin
            if (fr[r] >= 0 && fr[r] < NCLASS) begin
                if (cnt[fr[r]] == 0) first[fr[r]] = r;
`ifdef KNN_VOTE_WEIGHTED_EN
                cnt[fr[r]] += K - r;
`else
                cnt[fr[r]] += 1;
`endif
            end
        end
        e = '{label: 0, votes: 0, none: 1};
        for (int c = 0; c < NCLASS; c++) begin
            if (cnt[c] > 0 && (e.none == 1 || cnt[c] > e.votes ||
                               (cnt[c] == e.votes && first[c] < first[e.label]))) begin
                e.label = c;
                e.votes = cnt[c];
                e.none  = 0;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_entry(input int lb);
        int n = 0;
        nb_valid = 1'b1;
        nb_data  = {32'($urandom), L'(lb)};
        while (!nb_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("nb_ready_timeout", 0, 1);
        @(negedge clk);
        nb_valid = 1'b0;
    endtask

    task automatic send_labels(input frame_t fr);
        for (int r = 0; r < K; r++) send_entry(fr[r]);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic get_result(input int hold);
        exp_t e;
        int   n;
        if (hold == 0) out_ready = 1'b1;
        wait_valid(n);
        check("latency", n, NCLASS + 1);
        if (q.size() == 0) begin
            check("queue_empty", 0, 1);
            out_ready = 1'b0;
            return;
        end
        e = q.pop_front();
        check("label", int'(out_label), e.label);
        check("votes", int'(out_votes), e.votes);
        check("none", int'(out_none), e.none);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_label", int'(out_label), e.label);
            check("hold_votes", int'(out_votes), e.votes);
            check("hold_nb_ready", int'(nb_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0);
        check("nb_ready_back", int'(nb_ready), 1);
    endtask

    task automatic run_frame(input frame_t fr, input int hold);
        q.push_back(model(fr));
        send_labels(fr);
        get_result(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nb_ready"}, int'(nb_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_label"}, int'(out_label), 0);
        check({tag, "_out_votes"}, int'(out_votes), 0);
        check({tag, "_out_none"}, int'(out_none), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        f = '{3, 3, 5, 7};       run_frame(f, 0);
        f = '{5, 3, 3, 5};       run_frame(f, 0);
        f = '{20, 255, 16, 16};  run_frame(f, 0);
        f = '{6, 6, 8, 8};       run_frame(f, 10);
        f = '{9, 9, 9, 1};       run_frame(f, 0);

        // Abort a partial frame; its votes must not leak into the next one.
        send_entry(4);
        send_entry(4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_nb_ready", int'(nb_ready), 1);
        check("clr_out_valid", int'(out_valid), 0);
        f = '{2, 2, 4, 4};       run_frame(f, 0);

        // Abort while a result is waiting.
        f = '{7, 7, 7, 7};
        send_labels(f);
        wait_valid(n);
        check("clr_done_seen", int'(out_valid), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_done_valid", int'(out_valid), 0);
        check("clr_done_nb_ready", int'(nb_ready), 1);

        f = '{1, 2, 2, 9};       run_frame(f, 0);
        f = '{12, 0, 15, 0};     run_frame(f, 0);

        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < K; r++) f[r] = int'($urandom_range(0, 19));
            run_frame(f, i % 3);
        end

        // Reset during SCAN.
        f = '{1, 1, 2, 3};
        send_labels(f);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_scan");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset during DONE.
        f = '{8, 8, 8, 2};
        send_labels(f);
        wait_valid(n);
        check("rst_done_seen", int'(out_valid), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_done");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        f = '{11, 11, 0, 0};     run_frame(f, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
